// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// The data/address widths and register count here are shared with the
// register file itself.
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int REG_WIDTH  = 3;
    localparam int NUM_REGS   = 5;

    typedef enum logic {
        ARB_INIT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational rotating-priority arbiter.
// The search starts at rr_ptr and wraps modulo NUM_REQ; the first set
// request bit wins.
// Ports:
//   req    - request vector
//   rr_ptr - index holding the highest priority this cycle
//   gnt    - one-hot grant, all zero when no request is set
//   winner - index of the granted requester (0 when none)
//   valid  - a grant was issued
module rr_arbiter
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    import regfile_write_arbiter_pkg::*;

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single write port of the register file.
// After reset it zeroes registers 1..NUM_REGS-1 (one per cycle), then grants
// one writeback requester per cycle and registers its write onto the port.
// Writes to register 0 or to unimplemented addresses are granted but dropped.
// Build option: define REGARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); otherwise round-robin.
// Ports:
//   clk, reset (async, active-low)
//   req/req_addr/req_data - flattened per-requester write requests
//   gnt                   - combinational one-hot grant
//   regWrite/writeAddr/writeData - registered register-file write port
//   init_done             - high once the init pass has finished
module regfile_write_arbiter
#(
    parameter int DATA_WIDTH = regfile_write_arbiter_pkg::DATA_WIDTH,
    parameter int REG_WIDTH  = regfile_write_arbiter_pkg::REG_WIDTH,
    parameter int NUM_REQ    = 3,
    parameter int NUM_REGS   = regfile_write_arbiter_pkg::NUM_REGS
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          regWrite,
    output logic [REG_WIDTH-1:0]          writeAddr,
    output logic [DATA_WIDTH-1:0]         writeData,
    output logic                          init_done
);

    import regfile_write_arbiter_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [REG_WIDTH-1:0] LAST_ADDR = REG_WIDTH'(NUM_REGS - 1);
    // One extra bit so NUM_REGS == 2**REG_WIDTH is representable.
    localparam logic [REG_WIDTH:0]   NREGS_L   = (REG_WIDTH + 1)'(NUM_REGS);

    arb_state_t             state;
    logic [REG_WIDTH-1:0]   init_cnt;
    logic [PTR_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]       arb_winner;
    logic                   arb_valid;
    logic [REG_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   win_writable;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Requests stay pending during init: no grant is visible outside RUN.
    assign gnt = (state == ARB_RUN) ? arb_gnt : '0;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_addr = req_addr[i*REG_WIDTH +: REG_WIDTH];
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register 0 is hard-wired zero; addresses past NUM_REGS-1 do not exist.
    assign win_writable = (win_addr != '0) && ({1'b0, win_addr} < NREGS_L);

`ifdef REGARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (state == ARB_RUN && arb_valid) begin
            rr_ptr <= (arb_winner == PTR_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_INIT;
            init_cnt  <= REG_WIDTH'(1);
            regWrite  <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ARB_INIT: begin
                    regWrite  <= 1'b1;
                    writeAddr <= init_cnt;
                    writeData <= '0;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ARB_RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ARB_RUN: begin
                    if (arb_valid) begin
                        regWrite  <= win_writable;
                        writeAddr <= win_addr;
                        writeData <= win_data;
                    end else begin
                        regWrite  <= 1'b0;
                    end
                end
                default: state <= ARB_INIT;
            endcase
        end
    end

endmodule
